// File: rtl/reg_file.sv
// reg_file: general-purpose CPU register file fed by the MEM/WB writeback latch.
// Provides two combinational read ports with same-cycle write-to-read bypass
// and one synchronous write port. Entry 0 is hardwired to zero.
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int REG_NUM    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  read1_en,
   input  logic [ADDR_WIDTH-1:0] read1_addr,
   output logic [DATA_WIDTH-1:0] read1_data,
   input  logic                  read2_en,
   input  logic [ADDR_WIDTH-1:0] read2_addr,
   output logic [DATA_WIDTH-1:0] read2_data
);

   logic [DATA_WIDTH-1:0] r_regs [REG_NUM];

   logic w_wr_live;

   // A write only lands when not in reset and not targeting the zero register.
   assign w_wr_live = write_en && (write_addr != '0);

   // Storage update: reset clears every entry and swallows any write on that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_live) begin
         r_regs[write_addr] <= write_data;
      end
   end

   // Port 1 read: reset, disable and r0 force zero; a matching write is bypassed.
   always_comb begin
      read1_data = '0;
      if (!rst && read1_en && (read1_addr != '0)) begin
         if (write_en && (write_addr == read1_addr)) begin
            read1_data = write_data;
         end else begin
            read1_data = r_regs[read1_addr];
         end
      end
   end

   // Port 2 read: same priority as port 1, fully independent of it.
   always_comb begin
      read2_data = '0;
      if (!rst && read2_en && (read2_addr != '0)) begin
         if (write_en && (write_addr == read2_addr)) begin
            read2_data = write_data;
         end else begin
            read2_data = r_regs[read2_addr];
         end
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed stimulus for reg_file with a behavioural register model
// checked every cycle, plus hand-computed literal expectations.
module tb_reg_file;

   logic        clk;
   logic        rst;
   logic        write_en;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic        read1_en;
   logic [4:0]  read1_addr;
   logic [31:0] read1_data;
   logic        read2_en;
   logic [4:0]  read2_addr;
   logic [31:0] read2_data;

   int total;
   int bad;

   logic [31:0] m_regs [32];

   reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_NUM(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .write_en   (write_en),
      .write_addr (write_addr),
      .write_data (write_data),
      .read1_en   (read1_en),
      .read1_addr (read1_addr),
      .read1_data (read1_data),
      .read2_en   (read2_en),
      .read2_addr (read2_addr),
      .read2_data (read2_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // What a read port must return given the current inputs and the model contents.
   function automatic logic [31:0] exp_read(input logic en, input logic [4:0] addr);
      if (rst)                               return 32'h0;
      if (!en)                               return 32'h0;
      if (addr == 5'd0)                      return 32'h0;
      if (write_en && write_addr == addr)    return write_data;
      return m_regs[addr];
   endfunction

   // Model state: a plain array of 32 words updated on each rising edge.
   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      end else if (write_en && write_addr != 5'd0) begin
         m_regs[write_addr] = write_data;
      end
   end

   // Per-cycle comparison of both read ports against the model.
   always @(negedge clk) begin
      logic [31:0] e1, e2;
      e1 = exp_read(read1_en, read1_addr);
      e2 = exp_read(read2_en, read2_addr);
      total++;
      if (read1_data !== e1) begin
         bad++;
         $display("FAIL model_rd1 t=%0t addr=%0d got=%h exp=%h", $time, read1_addr, read1_data, e1);
      end
      total++;
      if (read2_data !== e2) begin
         bad++;
         $display("FAIL model_rd2 t=%0t addr=%0d got=%h exp=%h", $time, read2_addr, read2_data, e2);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rs, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic re1, input logic [4:0] ra1, input logic re2, input logic [4:0] ra2);
      @(posedge clk);
      #1;
      rst        = rs;
      write_en   = we;
      write_addr = wa;
      write_data = wd;
      read1_en   = re1;
      read1_addr = ra1;
      read2_en   = re2;
      read2_addr = ra2;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1; write_en = 1'b0; write_addr = 5'd0; write_data = 32'h0;
      read1_en = 1'b0; read1_addr = 5'd0; read2_en = 1'b0; read2_addr = 5'd0;

      // Reset forces outputs low even while a bypass-eligible write is present.
      drive(1, 1, 5'd7, 32'h0000_0077, 1, 5'd5, 1, 5'd7);
      mid();
      check("rst_out_rd1", read1_data, 32'h0);
      check("rst_out_rd2", read2_data, 32'h0);

      // The write to r7 made during reset was discarded.
      drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd7);
      mid();
      check("rst_discard_r7", read2_data, 32'h0);

      // Write r5, then reset, then r5 must read zero.
      drive(0, 1, 5'd5, 32'hDEAD_BEEF, 1, 5'd5, 0, 5'd0);
      mid();
      check("bypass_r5", read1_data, 32'hDEAD_BEEF);
      drive(0, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd0);
      mid();
      check("stored_r5", read1_data, 32'hDEAD_BEEF);
      drive(1, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd0);
      drive(0, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd0);
      mid();
      check("rst_clear_r5", read1_data, 32'h0);

      // Basic write then read on both ports; disabled port reads zero.
      drive(0, 1, 5'd3, 32'h1234_5678, 0, 5'd0, 0, 5'd0);
      drive(0, 0, 5'd0, 32'h0, 1, 5'd3, 1, 5'd3);
      mid();
      check("basic_rd1", read1_data, 32'h1234_5678);
      check("basic_rd2", read2_data, 32'h1234_5678);
      drive(0, 0, 5'd0, 32'h0, 0, 5'd3, 1, 5'd3);
      mid();
      check("basic_rd1_dis", read1_data, 32'h0);
      check("basic_rd2_en", read2_data, 32'h1234_5678);

      // Bypass over an older r9 value on both ports, then the new value sticks.
      drive(0, 1, 5'd9, 32'h1111_1111, 0, 5'd0, 0, 5'd0);
      drive(0, 1, 5'd9, 32'hA5A5_A5A5, 1, 5'd9, 1, 5'd9);
      mid();
      check("bypass_rd1", read1_data, 32'hA5A5_A5A5);
      check("bypass_rd2", read2_data, 32'hA5A5_A5A5);
      drive(0, 0, 5'd0, 32'h0, 1, 5'd9, 1, 5'd9);
      mid();
      check("after_bypass_r9", read1_data, 32'hA5A5_A5A5);

      // Zero register ignores writes and never bypasses.
      drive(0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 1, 5'd0);
      mid();
      check("r0_bypass_rd1", read1_data, 32'h0);
      check("r0_bypass_rd2", read2_data, 32'h0);
      drive(0, 0, 5'd0, 32'h0, 1, 5'd0, 0, 5'd0);
      mid();
      check("r0_after", read1_data, 32'h0);

      // Sweep: fill r1..r31, then read with mirrored addresses on the two ports.
      for (int a = 1; a < 32; a++) begin
         drive(0, 1, 5'(a), 32'(a) * 32'h0101_0101, 0, 5'd0, 0, 5'd0);
      end
      for (int a = 0; a < 32; a++) begin
         drive(0, 0, 5'd0, 32'h0, 1, 5'(a), 1, 5'(31 - a));
         mid();
         check($sformatf("sweep_rd1_a%0d", a), read1_data, 32'(a) * 32'h0101_0101);
         check($sformatf("sweep_rd2_a%0d", 31 - a), read2_data, 32'(31 - a) * 32'h0101_0101);
      end

      // Reset in the middle of a write aborts it and clears the whole array.
      drive(1, 1, 5'd12, 32'hCAFE_F00D, 1, 5'd12, 1, 5'd31);
      mid();
      check("mid_rst_rd1", read1_data, 32'h0);
      for (int a = 0; a < 32; a++) begin
         drive(0, 0, 5'd0, 32'h0, 1, 5'(a), 1, 5'(31 - a));
         mid();
         check($sformatf("post_rst_a%0d", a), read1_data, 32'h0);
      end

      drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0);
      mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
